star_frame_writer: RTL and testbench
====================================

// Module: star_frame_writer
// PURPOSE
//  Fills the 6x6, 3-bit star-image RAM from an incoming raster pixel stream (valid/ready handshake).
//  Write-side counterpart of the top/bottom and left/right edge finders, which only read this RAM.
//  Raster order: x fastest, then y. Address = y*WIDTH + x.
//  Pulses frame_done when the frame is fully stored. That pulse is the start trigger for the finder chain.
// PARAMETERS
//  X_SZ     3   x coordinate width
//  Y_SZ     3   y coordinate width
//  ADDR_SZ  6   RAM address width
//  COL_SZ   3   pixel value width
//  WIDTH    6   pixels per row
//  HEIGHT   6   rows per frame
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  reset        in   1        asynchronous, active-high; clears all state
//  start        in   1        begin a new frame; sampled only in IDLE
//  pix_valid    in   1        pix_data valid this cycle
//  pix_data     in   COL_SZ   pixel value
//  pix_ready    out  1        writer accepts a pixel this cycle
//  mem_address  out  ADDR_SZ  RAM address (registered)
//  mem_data     out  COL_SZ   RAM write data (registered)
//  mem_wren     out  1        RAM write strobe (registered)
//  busy         out  1        high from start accept until frame_done
//  frame_done   out  1        one-cycle pulse when the frame is stored
//  lit_count    out  ADDR_SZ  number of pixels != THRESHOLD in the last frame
// BEHAVIOUR
//  Reset values: every output is 0. FSM is in IDLE and x = y = 0.
//  Reset mid-frame: FSM aborts at once. No further mem_wren is issued. The next frame starts at address 0.
//  FSM states:
//   IDLE  : start -> WRITE (or CLEAR, see CONFIGURATION). Clear x, y and lit_count.
//   WRITE : pix_ready = 1. Accept = pix_valid & pix_ready.
//           Last pixel is x==WIDTH-1 && y==HEIGHT-1. Accepting it -> FLUSH.
//   FLUSH : single cycle; the final mem_wren is high here -> DONE.
//   DONE  : frame_done = 1 for one cycle, busy = 0 -> IDLE.
//  Accept at cycle N drives mem_address, mem_data and mem_wren = 1 during cycle N+1.
//  No accept in cycle N means mem_wren = 0 in cycle N+1.
//  Counter rule on each accept: x++ ; when x==WIDTH-1, x wraps to 0 and y++. y never wraps inside a frame.
//  Address = y*WIDTH + x, zero-extended, unsigned. For WIDTH=6 this is (y<<2)+(y<<1)+x. Max address is 35.
//  lit_count increments on an accept when pix_data != THRESHOLD (THRESHOLD = 0).
//  lit_count is stable from frame_done until the next start.
//  pix_ready is 0 in IDLE, CLEAR, FLUSH and DONE. pix_valid in those states is ignored.
//  start is ignored outside IDLE, including the DONE cycle.
//  start and pix_valid high in the same cycle in IDLE: pixel not taken; pix_ready rises the following cycle.
//  Frame latency with continuous valid: first accept at cycle 0, frame_done at cycle WIDTH*HEIGHT+1.
// CONFIGURATION
//  Macro WRITER_CLEAR_EN.
//  Defined:
//   - start -> CLEAR state.
//   - CLEAR writes 0 to addresses 0..WIDTH*HEIGHT-1, one per cycle. mem_wren = 1, pix_ready = 0.
//   - Then -> WRITE. Adds WIDTH*HEIGHT cycles before the first accept.
//  Undefined: CLEAR state is not compiled; start -> WRITE directly.
// STRUCTURE
//  Package star_pkg:
//   - state enum typedef
//   - WIDTH/HEIGHT defaults
//   - THRESHOLD constant, shared with the finders
//  Sub-module frame_addr_calc: combinational (x,y) -> address, shift-add form.
// TESTING
//  T1 reset: assert reset mid-idle -> all outputs 0, pix_ready 0.
//     pix_valid=1 with no start -> no mem_wren.
//  T2 full frame, continuous valid, pix_data = i%8 for i=0..35:
//     mem_wren at cycles 1..36 with address i, data i%8.
//     frame_done only at cycle 37. lit_count = 31.
//  T3 backpressure: pix_valid on alternate cycles -> mem_wren only the cycle after each accept.
//     Addresses strictly 0..35 in order. frame_done once.
//  T4 start pulsed during WRITE and during the DONE cycle -> ignored.
//     Exactly 36 writes. A second start in IDLE begins again at address 0.
//  T5 reset asserted after 10 accepts -> no further mem_wren, busy 0.
//     Next start writes address 0 first.
//  T6 WRITER_CLEAR_EN defined: start -> 36 writes of data 0 to addresses 0..35 with pix_ready 0.
//     Then pix_ready 1. T2 data follows with frame_done 36 cycles later than in T2.

Source files
------------

// File: rtl/star_pkg.sv
// rtl/star_pkg.sv - shared state type and frame constants for the star-image RAM writer and finders
package star_pkg;

    localparam int DEFAULT_WIDTH  = 6;
    localparam int DEFAULT_HEIGHT = 6;
    localparam int THRESHOLD      = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WRITE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/frame_addr_calc.sv
// rtl/frame_addr_calc.sv - combinational (x,y) to RAM address for a 6-pixel-wide frame
module frame_addr_calc #(
    parameter int X_SZ    = 3,
    parameter int Y_SZ    = 3,
    parameter int ADDR_SZ = 6
) (
    input  logic [X_SZ-1:0]    x,
    input  logic [Y_SZ-1:0]    y,
    output logic [ADDR_SZ-1:0] addr
);

    // y*6 + x written as (y<<2) + (y<<1) + x so no multiplier is built
    always_comb begin
        addr = ADDR_SZ'({y, 2'b00}) + ADDR_SZ'({y, 1'b0}) + ADDR_SZ'(x);
    end

endmodule

// File: rtl/star_frame_writer.sv
// rtl/star_frame_writer.sv - raster pixel stream to star-image RAM writer, optional pre-clear under WRITER_CLEAR_EN
module star_frame_writer
    import star_pkg::*;
#(
    parameter int X_SZ    = 3,
    parameter int Y_SZ    = 3,
    parameter int ADDR_SZ = 6,
    parameter int COL_SZ  = 3,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int HEIGHT  = DEFAULT_HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pix_valid,
    input  logic [COL_SZ-1:0]  pix_data,
    output logic               pix_ready,
    output logic [ADDR_SZ-1:0] mem_address,
    output logic [COL_SZ-1:0]  mem_data,
    output logic               mem_wren,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_SZ-1:0] lit_count
);

    localparam logic [X_SZ-1:0]    X_LAST    = X_SZ'(WIDTH - 1);
    localparam logic [Y_SZ-1:0]    Y_LAST    = Y_SZ'(HEIGHT - 1);
`ifdef WRITER_CLEAR_EN
    localparam logic [ADDR_SZ-1:0] ADDR_LAST = ADDR_SZ'(WIDTH * HEIGHT - 1);
`endif

    state_t             state;
    logic [X_SZ-1:0]    x;
    logic [Y_SZ-1:0]    y;
    logic [ADDR_SZ-1:0] pix_addr;
    logic               accept;

    frame_addr_calc #(
        .X_SZ    (X_SZ),
        .Y_SZ    (Y_SZ),
        .ADDR_SZ (ADDR_SZ)
    ) u_addr (
        .x    (x),
        .y    (y),
        .addr (pix_addr)
    );

    // status and handshake decode straight from the state register
    always_comb begin
        pix_ready  = (state == ST_WRITE);
        accept     = pix_valid & pix_ready;
        busy       = (state != ST_IDLE) && (state != ST_DONE);
        frame_done = (state == ST_DONE);
    end

    // frame FSM, raster counters and the registered RAM write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            x           <= '0;
            y           <= '0;
            lit_count   <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    x <= '0;
                    y <= '0;
                    if (start) begin
                        lit_count <= '0;
`ifdef WRITER_CLEAR_EN
                        // first clear write is presented on the first CLEAR cycle
                        state       <= ST_CLEAR;
                        mem_address <= '0;
                        mem_data    <= '0;
                        mem_wren    <= 1'b1;
`else
                        state <= ST_WRITE;
`endif
                    end
                end
`ifdef WRITER_CLEAR_EN
                ST_CLEAR: begin
                    if (mem_address == ADDR_LAST) begin
                        state <= ST_WRITE;
                    end else begin
                        mem_address <= mem_address + ADDR_SZ'(1);
                        mem_wren    <= 1'b1;
                    end
                end
`endif
                ST_WRITE: begin
                    if (accept) begin
                        mem_address <= pix_addr;
                        mem_data    <= pix_data;
                        mem_wren    <= 1'b1;
                        if (pix_data != COL_SZ'(THRESHOLD)) begin
                            lit_count <= lit_count + ADDR_SZ'(1);
                        end
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + Y_SZ'(1);
                            if (y == Y_LAST) begin
                                state <= ST_FLUSH;
                            end
                        end else begin
                            x <= x + X_SZ'(1);
                        end
                    end
                end
                ST_FLUSH: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_frame_writer.sv
// tb/tb_star_frame_writer.sv - scoreboard bench for star_frame_writer
module tb_star_frame_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [2:0] pix_data = 3'd0;
    logic       pix_ready;
    logic [5:0] mem_address;
    logic [2:0] mem_data;
    logic       mem_wren;
    logic       busy;
    logic       frame_done;
    logic [5:0] lit_count;

    star_frame_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .busy        (busy),
        .frame_done  (frame_done),
        .lit_count   (lit_count)
    );

    always #5 clk = ~clk;

`ifdef WRITER_CLEAR_EN
    localparam int CLR_CYC = 36;
`else
    localparam int CLR_CYC = 0;
`endif

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_total = 0;
    int   done_total = 0;
    int   last_done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            done_total++;
            last_done_cyc = cyc;
        end
        if (mem_wren) begin
            wr_total++;
            if (sb.size() == 0) begin
                chk("unexpected_wren", {31'd0, mem_wren}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", {26'd0, mem_address}, e.addr);
                chk("wr_data", {29'd0, mem_data}, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // mode 0: continuous, data i%8; 1: valid on alternate cycles; 2: spurious starts; 3: reset after 10 accepts
    task automatic run_frame(input int mode);
        int i = 0;
        int budget = 0;
        int c0;
        int last_acc = 0;
        int lit_exp = 0;
        int wr0;
        int done0;
        int limit;
        logic [2:0] d;
        wr0 = wr_total;
        done0 = done_total;
        limit = (mode == 3) ? 10 : 36;
        @(posedge clk); #1;
        start = 1'b1;
        pix_valid = (mode == 1);
        pix_data = 3'd5;
`ifdef WRITER_CLEAR_EN
        for (int k = 0; k < 36; k++) sb.push_back('{k, 0, cyc + 1 + k});
`endif
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, pix_ready}, (CLR_CYC == 0) ? 32'd1 : 32'd0);
        while (i < limit && budget < 400) begin
            d = (mode == 0) ? 3'(i % 8) : 3'($urandom_range(0, 7));
            pix_valid = (mode == 1) ? ((budget % 2) == 1) : 1'b1;
            pix_data = d;
            start = (mode == 2) && (budget == 5 || budget == 20 || budget == 71);
            if (pix_valid && pix_ready) begin
                sb.push_back('{i, int'(d), cyc + 1});
                if (d != 3'd0) lit_exp++;
                last_acc = cyc;
                i++;
            end
            @(posedge clk); #1;
            budget++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        if (i < limit) chk("accept_timeout", i, limit);
        if (mode == 3) begin
            @(posedge clk); #1;
            reset = 1'b1;
            pix_valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("abort_wren", {31'd0, mem_wren}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
            end
            chk("abort_lit", {26'd0, lit_count}, 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            pix_valid = 1'b0;
            chk("abort_sb_empty", sb.size(), 32'd0);
            return;
        end
        start = (mode == 2);
        budget = 0;
        while (!frame_done && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("done_seen", {31'd0, frame_done}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("writes", wr_total - wr0, 36 + CLR_CYC);
        chk("done_pulses", done_total - done0, 32'd1);
        chk("done_cycle", last_done_cyc, last_acc + 2);
        if (mode == 0) chk("done_latency", last_done_cyc - c0, 37 + CLR_CYC);
        chk("lit_count", {26'd0, lit_count}, lit_exp);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("ready_idle", {31'd0, pix_ready}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_addr", {26'd0, mem_address}, 32'd0);
        chk("rst_data", {29'd0, mem_data}, 32'd0);
        chk("rst_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_lit", {26'd0, lit_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        pix_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, pix_ready}, 32'd0);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_frame(0);
        chk("t2_lit", {26'd0, lit_count}, 32'd31);
        run_frame(1);
        run_frame(2);
        run_frame(0);
        run_frame(3);
        run_frame(0);
        chk("final_lit", {26'd0, lit_count}, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
